// File: rtl/mem_stage_access_if.sv
// mem_stage_access_if
//   Request/acknowledge data-memory port between the MEM stage and data memory.
//   master : the MEM stage. It drives MemReq/MemWe/MemAddr/MemWdata/MemBe
//            and receives MemAck/MemRdata.
//   slave  : the data memory, with the directions reversed.
//   MemAck is a one-cycle completion pulse. MemRdata is valid while MemAck is high.
interface mem_stage_access_if #(
    parameter int ADDR_W = 32
);
    logic              MemReq;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       MemWdata;
    logic [3:0]        MemBe;
    logic              MemAck;
    logic [31:0]       MemRdata;

    modport master (
        output MemReq, MemWe, MemAddr, MemWdata, MemBe,
        input  MemAck, MemRdata
    );

    modport slave (
        input  MemReq, MemWe, MemAddr, MemWdata, MemBe,
        output MemAck, MemRdata
    );
endinterface

// File: rtl/mem_stage_access.sv
// mem_stage_access
//   MEM-stage consumer of the EX/MEM register. It turns the MemRead/MemWrite
//   size codes into load/store transactions on a req/ack memory port. It holds
//   the upstream pipeline (Stall) while a transaction is outstanding. It also
//   formats load data and drives the MEM/WB fields.
//
//   Parameters
//     ADDR_W  : memory byte-address width (<= 32); MemAddr is word aligned
//     TIMEOUT : BUSY cycles without MemAck before abandoning (0 = never)
//
//   Ports
//     Clk, Rst        : clock (rising edge) and asynchronous active-high reset
//     Valid, Flush    : EX/MEM slot qualifier and squash
//     WBin, WriteReg  : write-back control and destination from EX/MEM
//     MemRead/Write   : access size, 00 none / 01 byte / 10 half / 11 word
//     ALUResult       : address for memory ops, pass-through otherwise
//     ReadData2       : store data
//     mem             : data-memory port (mem_stage_access_if.master)
//     Stall           : combinational hold request to upstream stages
//     BusErr          : one-cycle pulse on timeout (or misaligned trap)
//     WBout, ReadDataout, ALUResultout, WriteRegout : MEM/WB fields
//
//   Build option
//     MISALIGN_TRAP_EN : if defined, misaligned half/word accesses trap with a
//     BusErr pulse and a bubble. If undefined, the low address bits are
//     truncated to the access size.
module mem_stage_access #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Valid,
    input  logic        Flush,
    input  logic [1:0]  WBin,
    input  logic [1:0]  MemRead,
    input  logic [1:0]  MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [4:0]  WriteReg,
    input  logic [31:0] ReadData2,
    mem_stage_access_if.master mem,
    output logic        Stall,
    output logic        BusErr,
    output logic [1:0]  WBout,
    output logic [31:0] ReadDataout,
    output logic [31:0] ALUResultout,
    output logic [4:0]  WriteRegout
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              err_q, err_d;
    logic [1:0]        wb_q, wb_d;
    logic [31:0]       rd_q, rd_d;
    logic [31:0]       alu_q, alu_d;
    logic [4:0]        wr_q, wr_d;
    // Instruction fields captured at issue and retired when the ack arrives.
    logic [1:0]        cap_wb_q, cap_wb_d;
    logic [4:0]        cap_wr_q, cap_wr_d;
    logic [31:0]       cap_alu_q, cap_alu_d;
    logic [1:0]        cap_size_q, cap_size_d;
    logic [1:0]        cap_lo_q, cap_lo_d;

    logic       go;
    logic       store;
    logic [1:0] size;
    logic [1:0] lo;
    logic       memop;
    logic       misalign;
    logic       timeout_hit;

    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b01:   byte_en = 4'b0001 << a;
            2'b10:   byte_en = a[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b01:   store_lanes = {4{d[7:0]}};
            2'b10:   store_lanes = {2{d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

    function automatic logic [31:0] load_format(input logic [1:0] sz, input logic [1:0] a,
                                                input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'b00:   b = d[7:0];
            2'b01:   b = d[15:8];
            2'b10:   b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        case (sz)
            2'b01:   load_format = {{24{b[7]}}, b};
            2'b10:   load_format = {{16{h[15]}}, h};
            default: load_format = d;
        endcase
    endfunction

    assign go    = Valid & ~Flush;
    // When both codes are nonzero the store takes priority.
    assign store = (MemWrite != 2'b00);
    assign size  = store ? MemWrite : MemRead;
    assign lo    = ALUResult[1:0];
    assign memop = go & (size != 2'b00);

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((size == 2'b10) & lo[0]) | ((size == 2'b11) & (lo != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        err_d      = 1'b0;
        wb_d       = wb_q;
        rd_d       = rd_q;
        alu_d      = alu_q;
        wr_d       = wr_q;
        cap_wb_d   = cap_wb_q;
        cap_wr_d   = cap_wr_q;
        cap_alu_d  = cap_alu_q;
        cap_size_d = cap_size_q;
        cap_lo_d   = cap_lo_q;
        Stall      = 1'b0;

        case (state_q)
            IDLE: begin
                if (memop && !misalign) begin
                    Stall      = 1'b1;
                    req_d      = 1'b1;
                    we_d       = store;
                    addr_d     = {ALUResult[ADDR_W-1:2], 2'b00};
                    be_d       = byte_en(size, lo);
                    wdata_d    = store_lanes(size, ReadData2);
                    cap_wb_d   = WBin;
                    cap_wr_d   = WriteReg;
                    cap_alu_d  = ALUResult;
                    cap_size_d = size;
                    cap_lo_d   = lo;
                    wb_d       = 2'b00;
                    cnt_d      = '0;
                    state_d    = BUSY;
                end else if (memop) begin
                    // Misaligned access trapped: no request, bubble plus error pulse.
                    err_d = 1'b1;
                    wb_d  = 2'b00;
                end else if (go) begin
                    wb_d  = WBin;
                    alu_d = ALUResult;
                    wr_d  = WriteReg;
                    rd_d  = 32'd0;
                end else begin
                    wb_d = 2'b00;
                end
            end
            BUSY: begin
                // Flush is ignored here because an issued store must complete.
                if (mem.MemAck) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    wb_d    = cap_wb_q;
                    alu_d   = cap_alu_q;
                    wr_d    = cap_wr_q;
                    rd_d    = we_q ? 32'd0 : load_format(cap_size_q, cap_lo_q, mem.MemRdata);
                end else if (timeout_hit) begin
                    // Abandon: the destination is not written and upstream is released.
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    wb_d    = 2'b00;
                    state_d = IDLE;
                end else begin
                    Stall = 1'b1;
                    wb_d  = 2'b00;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            err_q      <= 1'b0;
            wb_q       <= '0;
            rd_q       <= '0;
            alu_q      <= '0;
            wr_q       <= '0;
            cap_wb_q   <= '0;
            cap_wr_q   <= '0;
            cap_alu_q  <= '0;
            cap_size_q <= '0;
            cap_lo_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            err_q      <= err_d;
            wb_q       <= wb_d;
            rd_q       <= rd_d;
            alu_q      <= alu_d;
            wr_q       <= wr_d;
            cap_wb_q   <= cap_wb_d;
            cap_wr_q   <= cap_wr_d;
            cap_alu_q  <= cap_alu_d;
            cap_size_q <= cap_size_d;
            cap_lo_q   <= cap_lo_d;
        end
    end

    assign mem.MemReq   = req_q;
    assign mem.MemWe    = we_q;
    assign mem.MemAddr  = addr_q;
    assign mem.MemWdata = wdata_q;
    assign mem.MemBe    = be_q;
    assign BusErr       = err_q;
    assign WBout        = wb_q;
    assign ReadDataout  = rd_q;
    assign ALUResultout = alu_q;
    assign WriteRegout  = wr_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// tb_mem_stage_access
//   Bench for mem_stage_access with TIMEOUT = 4.
//   Directed vectors come from a table, and randomized transactions are scored
//   by an arithmetic reference model. Hand-written sequences cover reset,
//   timeout, reset during BUSY and MemAck while IDLE.
module tb_mem_stage_access;

    localparam int TO = 4;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Valid, Flush;
    logic [1:0]  WBin, MemRead, MemWrite;
    logic [31:0] ALUResult, ReadData2;
    logic [4:0]  WriteReg;
    logic        Stall, BusErr;
    logic [1:0]  WBout;
    logic [31:0] ReadDataout, ALUResultout;
    logic [4:0]  WriteRegout;

    mem_stage_access_if #(.ADDR_W(32)) bus ();

    mem_stage_access #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Rst(Rst), .Valid(Valid), .Flush(Flush), .WBin(WBin),
        .MemRead(MemRead), .MemWrite(MemWrite), .ALUResult(ALUResult),
        .WriteReg(WriteReg), .ReadData2(ReadData2), .mem(bus),
        .Stall(Stall), .BusErr(BusErr), .WBout(WBout), .ReadDataout(ReadDataout),
        .ALUResultout(ALUResultout), .WriteRegout(WriteRegout)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        valid, flush;
        logic [1:0]  wb, mr, mw;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [31:0] rd2, rdata;
        int          delay;
        logic        fb;
        logic        e_req, e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [1:0]  e_wb;
        logic        e_hold;
        logic [31:0] e_rd, e_alu;
        logic [4:0]  e_wr;
        logic        e_err;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rd, last_alu;
    logic [4:0]  last_wr;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic idle_inputs();
        Valid = 1'b0; Flush = 1'b0; MemRead = 2'b00; MemWrite = 2'b00;
        WBin = 2'b00; ALUResult = 32'd0; WriteReg = 5'd0; ReadData2 = 32'd0;
    endtask

    function automatic vec_t vin(input logic valid, input logic flush, input logic [1:0] wb,
                                 input logic [1:0] mr, input logic [1:0] mw, input logic [31:0] alu,
                                 input logic [4:0] wr, input logic [31:0] rd2,
                                 input logic [31:0] rdata, input int delay, input logic fb);
        vec_t v;
        v.valid = valid; v.flush = flush; v.wb = wb; v.mr = mr; v.mw = mw; v.alu = alu;
        v.wr = wr; v.rd2 = rd2; v.rdata = rdata; v.delay = delay; v.fb = fb;
        v.e_req = 0; v.e_we = 0; v.e_addr = 0; v.e_be = 0; v.e_wdata = 0; v.e_wb = 0;
        v.e_hold = 0; v.e_rd = 0; v.e_alu = 0; v.e_wr = 0; v.e_err = 0;
        return v;
    endfunction

    function automatic vec_t ex(input vec_t v, input logic req, input logic we,
                                input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [1:0] wb, input logic hold,
                                input logic [31:0] rd, input logic [31:0] alu,
                                input logic [4:0] wr, input logic err);
        vec_t r = v;
        r.e_req = req; r.e_we = we; r.e_addr = addr; r.e_be = be; r.e_wdata = wdata;
        r.e_wb = wb; r.e_hold = hold; r.e_rd = rd; r.e_alu = alu; r.e_wr = wr; r.e_err = err;
        return r;
    endfunction

    // Reference model: derives expectations from the access rules with plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic        go, st;
        logic [1:0]  sz, a;
        logic [31:0] lane;
        go = v.valid && !v.flush;
        st = (v.mw != 0);
        sz = st ? v.mw : v.mr;
        a  = v.alu[1:0];
        r = ex(v, 0, 0, 0, 0, 0, v.wb, 0, 0, v.alu, v.wr, 0);
        if (!go) begin
            r.e_wb = 0; r.e_hold = 1;
        end else if (sz != 0) begin
`ifdef MISALIGN_TRAP_EN
            if ((sz == 2 && a[0]) || (sz == 3 && a != 0)) begin
                r.e_wb = 0; r.e_hold = 1; r.e_err = 1;
                return r;
            end
`endif
            r.e_req  = 1;
            r.e_we   = st;
            r.e_addr = v.alu - 32'(a);
            if (sz == 1) begin
                r.e_be    = 4'(1 << a);
                r.e_wdata = 32'(v.rd2[7:0]) * 32'h01010101;
                lane = (v.rdata >> (8 * a)) & 32'hFF;
                if (lane >= 32'h80) lane = lane + 32'hFFFFFF00;
            end else if (sz == 2) begin
                r.e_be    = (a >= 2) ? 4'hC : 4'h3;
                r.e_wdata = 32'(v.rd2[15:0]) * 32'h00010001;
                lane = (v.rdata >> (16 * (a / 2))) & 32'hFFFF;
                if (lane >= 32'h8000) lane = lane + 32'hFFFF0000;
            end else begin
                r.e_be    = 4'hF;
                r.e_wdata = v.rd2;
                lane = v.rdata;
            end
            r.e_rd = st ? 32'd0 : lane;
        end
        return r;
    endfunction

    // Applies one EX/MEM slot at a negedge and checks it until retirement.
    task automatic apply(input vec_t v);
        int stalls;
        Valid = v.valid; Flush = v.flush; WBin = v.wb; MemRead = v.mr; MemWrite = v.mw;
        ALUResult = v.alu; WriteReg = v.wr; ReadData2 = v.rd2;
        bus.MemAck = 1'b0;
        #1;
        if (v.e_req) begin
            chk("stall_issue", 32'(Stall), 32'd1);
            step();
            chk("req_rise", 32'(bus.MemReq), 32'd1);
            chk("mem_we", 32'(bus.MemWe), 32'(v.e_we));
            chk("mem_addr", bus.MemAddr, v.e_addr);
            chk("mem_be", 32'(bus.MemBe), 32'(v.e_be));
            chk("mem_wdata", bus.MemWdata, v.e_wdata);
            chk("wbout_busy", 32'(WBout), 32'd0);
            stalls = 1;
            for (int k = 0; k < v.delay; k++) begin
                if (v.fb) begin Flush = 1'b1; Valid = 1'b0; end
                #1;
                if (Stall) stalls++;
                chk("req_hold", 32'(bus.MemReq), 32'd1);
                step();
            end
            bus.MemAck = 1'b1; bus.MemRdata = v.rdata;
            #1;
            chk("stall_ack", 32'(Stall), 32'd0);
            chk("stall_cycles", 32'(stalls), 32'(v.delay + 1));
            step();
            bus.MemAck = 1'b0; bus.MemRdata = $urandom;
        end else begin
            chk("stall_none", 32'(Stall), 32'd0);
            step();
        end
        chk("req_low", 32'(bus.MemReq), 32'd0);
        chk("buserr", 32'(BusErr), 32'(v.e_err));
        chk("wbout", 32'(WBout), 32'(v.e_wb));
        if (!v.e_hold) begin
            last_rd = v.e_rd; last_alu = v.e_alu; last_wr = v.e_wr;
        end
        chk("readdata", ReadDataout, last_rd);
        chk("aluresult", ALUResultout, last_alu);
        chk("writereg", 32'(WriteRegout), 32'(last_wr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1;
        idle_inputs();
        bus.MemAck = 1'b0; bus.MemRdata = 32'd0;
        last_rd = 0; last_alu = 0; last_wr = 0;
        @(posedge Clk); @(negedge Clk);
        chk("rst_req", 32'(bus.MemReq), 32'd0);
        chk("rst_we", 32'(bus.MemWe), 32'd0);
        chk("rst_addr", bus.MemAddr, 32'd0);
        chk("rst_wdata", bus.MemWdata, 32'd0);
        chk("rst_be", 32'(bus.MemBe), 32'd0);
        chk("rst_err", 32'(BusErr), 32'd0);
        chk("rst_wb", 32'(WBout), 32'd0);
        chk("rst_rd", ReadDataout, 32'd0);
        chk("rst_alu", ALUResultout, 32'd0);
        chk("rst_wr", 32'(WriteRegout), 32'd0);
        Rst = 1'b0;
        step();

        // Directed table
        tbl.push_back(ex(vin(1,0,2'b10,2'b00,2'b00,32'h1234,5'd5,0,0,0,0),
                         0,0,0,0,0,2'b10,0,0,32'h1234,5'd5,0));
        tbl.push_back(ex(vin(0,0,2'b11,2'b00,2'b00,32'hFFFF,5'd9,0,0,0,0),
                         0,0,0,0,0,2'b00,1,0,0,0,0));
        tbl.push_back(ex(vin(1,0,2'b01,2'b01,2'b00,32'h103,5'd7,32'h11223344,32'h80123456,3,0),
                         1,0,32'h100,4'b1000,32'h44444444,2'b01,0,32'hFFFFFF80,32'h103,5'd7,0));
        tbl.push_back(ex(vin(1,0,2'b11,2'b00,2'b10,32'h202,5'd9,32'h0000ABCD,0,1,0),
                         1,1,32'h200,4'b1100,32'hABCDABCD,2'b11,0,0,32'h202,5'd9,0));
        tbl.push_back(ex(vin(1,1,2'b01,2'b11,2'b00,32'h400,5'd3,0,0,0,0),
                         0,0,0,0,0,2'b00,1,0,0,0,0));
`ifdef MISALIGN_TRAP_EN
        tbl.push_back(ex(vin(1,0,2'b01,2'b11,2'b00,32'h102,5'd3,0,32'hDEADBEEF,0,0),
                         0,0,0,0,0,2'b00,1,0,0,0,1));
`else
        tbl.push_back(ex(vin(1,0,2'b01,2'b11,2'b00,32'h102,5'd3,0,32'hDEADBEEF,0,0),
                         1,0,32'h100,4'hF,32'h0,2'b01,0,32'hDEADBEEF,32'h102,5'd3,0));
`endif
        tbl.push_back(ex(vin(1,0,2'b10,2'b10,2'b00,32'h102,5'd12,0,32'h80017FFF,2,0),
                         1,0,32'h100,4'b1100,32'h0,2'b10,0,32'hFFFF8001,32'h102,5'd12,0));
        tbl.push_back(ex(vin(1,0,2'b01,2'b01,2'b00,32'h1,5'd1,0,32'h00007F00,0,0),
                         1,0,32'h0,4'b0010,32'h0,2'b01,0,32'h7F,32'h1,5'd1,0));
        tbl.push_back(ex(vin(1,0,2'b10,2'b11,2'b01,32'h10,5'd2,32'h5A,32'hFFFFFFFF,1,0),
                         1,1,32'h10,4'b0001,32'h5A5A5A5A,2'b10,0,0,32'h10,5'd2,0));
        tbl.push_back(ex(vin(1,0,2'b01,2'b00,2'b11,32'h40,5'd6,32'h12345678,0,2,1),
                         1,1,32'h40,4'hF,32'h12345678,2'b01,0,0,32'h40,5'd6,0));
        tbl.push_back(ex(vin(1,0,2'b11,2'b00,2'b00,32'hCAFE0000,5'd31,0,0,0,0),
                         0,0,0,0,0,2'b11,0,0,32'hCAFE0000,5'd31,0));
        foreach (tbl[i]) apply(tbl[i]);

        // MemAck while IDLE is ignored
        idle_inputs();
        bus.MemAck = 1'b1; bus.MemRdata = 32'h12345678;
        #1;
        chk("idle_ack_stall", 32'(Stall), 32'd0);
        step();
        bus.MemAck = 1'b0;
        chk("idle_ack_req", 32'(bus.MemReq), 32'd0);
        chk("idle_ack_rd", ReadDataout, last_rd);

        // Timeout: never acknowledged
        Valid = 1'b1; MemRead = 2'b11; ALUResult = 32'h300; WBin = 2'b11; WriteReg = 5'd4;
        step();
        chk("to_req_rise", 32'(bus.MemReq), 32'd1);
        idle_inputs();
        for (int k = 1; k < TO; k++) begin
            chk("to_stall", 32'(Stall), 32'd1);
            chk("to_err_early", 32'(BusErr), 32'd0);
            step();
        end
        chk("to_stall_fall", 32'(Stall), 32'd0);
        step();
        chk("to_buserr", 32'(BusErr), 32'd1);
        chk("to_req_drop", 32'(bus.MemReq), 32'd0);
        chk("to_wbout", 32'(WBout), 32'd0);
        chk("to_alu_hold", ALUResultout, last_alu);
        step();
        chk("to_err_pulse", 32'(BusErr), 32'd0);

        // Reset during BUSY
        Valid = 1'b1; MemRead = 2'b01; ALUResult = 32'h55; WBin = 2'b01; WriteReg = 5'd8;
        step();
        chk("rb_req", 32'(bus.MemReq), 32'd1);
        idle_inputs();
        #2 Rst = 1'b1;
        #1;
        chk("rb_req_drop", 32'(bus.MemReq), 32'd0);
        chk("rb_alu", ALUResultout, 32'd0);
        chk("rb_stall", 32'(Stall), 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        last_rd = 0; last_alu = 0; last_wr = 0;
        step();
        chk("rb_idle", 32'(bus.MemReq), 32'd0);

        // Randomized transactions against the reference model
        for (int n = 0; n < 60; n++) begin
            vec_t v;
            logic [1:0] mr, mw;
            mr = 2'($urandom);
            mw = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            if ($urandom_range(0, 3) == 0) begin mr = 0; mw = 0; end
            v = vin($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, 2'($urandom),
                    mr, mw, $urandom, 5'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, 3)), 1'($urandom));
            apply(model(v));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_access.md
Name: mem_stage_access

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns the registered MemRead/MemWrite size codes into load/store transactions on a req/ack data-memory port.
- Stalls the upstream pipeline while a transaction is outstanding.
- Formats load data and drives the MEM/WB register fields (WBout, ReadDataout, ALUResultout, WriteRegout) toward write-back.

Parameters:
- ADDR_W, 32, data-memory byte-address width; MemAddr = {ALUResult[ADDR_W-1:2], 2'b00}.
- TIMEOUT, 64, cycles waiting for MemAck before abandoning; 0 disables the timeout.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- Valid  in  1  EX/MEM slot holds a real instruction.
- Flush  in  1  squash the incoming instruction (taken branch).
- WBin  in  2  write-back control from EX/MEM.
- MemRead  in  2  load size: 00 none, 01 byte, 10 half, 11 word.
- MemWrite  in  2  store size, same encoding.
- ALUResult  in  32  address / pass-through result.
- WriteReg  in  5  destination register.
- ReadData2  in  32  store data.
- MemReq  out  1  memory request, registered.
- MemWe  out  1  1 = store.
- MemAddr  out  ADDR_W  word-aligned address.
- MemWdata  out  32  lane-replicated store data.
- MemBe  out  4  byte enables.
- MemAck  in  1  one-cycle completion pulse.
- MemRdata  in  32  read word, valid with MemAck.
- Stall  out  1  combinational; upstream holds EX/MEM while high.
- BusErr  out  1  one-cycle pulse on timeout.
- WBout  out  2  MEM/WB write-back control.
- ReadDataout  out  32  formatted load data.
- ALUResultout  out  32  MEM/WB ALU result.
- WriteRegout  out  5  MEM/WB destination register.

Behaviour:
- Reset: every output register is cleared to 0 (MemReq, MemWe, MemAddr, MemWdata, MemBe, BusErr, WBout, ReadDataout, ALUResultout, WriteRegout). State = IDLE, timeout counter = 0.
- Reset is asynchronous. Asserting it during BUSY drops MemReq immediately and abandons the transaction.
- Definitions:
  - go = Valid & !Flush.
  - memop = go & (MemRead != 0 | MemWrite != 0).
  - If MemRead and MemWrite are both nonzero, the store wins.
- IDLE, go & !memop:
  - next edge loads WBout=WBin, ALUResultout=ALUResult, WriteRegout=WriteReg, ReadDataout=0. Latency 1.
- IDLE, !go:
  - next edge inserts a bubble: WBout=0; other MEM/WB fields hold.
- IDLE, memop:
  - Stall=1 combinationally.
  - Next edge: MemReq=1; MemWe, MemAddr, MemBe, MemWdata registered; captured WBin/WriteReg/ALUResult/size/addr[1:0] held internally; WBout=0; state goes to BUSY.
- Byte enables and store data:
  - byte: MemBe = 1<<addr[1:0]; MemWdata = {4{data[7:0]}}.
  - half: MemBe = addr[1] ? 1100 : 0011; MemWdata = {2{data[15:0]}}.
  - word: MemBe = 1111; MemWdata = data.
- BUSY, MemAck=0:
  - Stall=1, WBout=0 each cycle, counter increments.
  - Flush is ignored in BUSY: an issued store must complete.
- BUSY, MemAck=1:
  - Stall=0 that cycle, so upstream advances on the same edge.
  - At the edge: MemReq=0, state goes to IDLE, MEM/WB fields load from the captured values.
  - ReadDataout = selected lane, sign-extended (byte/half) or full word; 0 for stores.
  - Minimum memory-op occupancy is 2 cycles. Back-to-back memory ops reissue MemReq after one IDLE cycle.
- Timeout (TIMEOUT != 0): when the counter reaches TIMEOUT-1 with no ack:
  - MemReq=0, BusErr=1 for one cycle, WBout=0 (destination not written), state goes to IDLE, Stall=0 that cycle.
  - Counter clears on entry to BUSY.
- MemAck while IDLE is ignored.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, issues no request. The next edge pulses BusErr and writes a bubble (WBout=0). Latency 1; no stall beyond the IDLE cycle.
- Undefined: misaligned low address bits are silently truncated to the access size (half uses addr[1]; word ignores addr[1:0]), and the access proceeds normally.

Test Plan:
- ALU op, Valid=1, WBin=10, ALUResult=0x1234, WriteReg=5 -> one edge later WBout=10, ALUResultout=0x1234, WriteRegout=5, Stall never 1.
- Byte load, MemRead=01, ALUResult=0x103, ack after 3 cycles with MemRdata=0x80xxxxxx -> MemBe=1000; Stall high 4 cycles; ReadDataout=0xFFFFFF80.
- Half store, MemWrite=10, ALUResult=0x202, ReadData2=0xABCD -> MemWe=1, MemBe=1100, MemWdata=0xABCDABCD; WBout=WBin after ack.
- Flush=1 with MemRead=11 in IDLE -> MemReq stays 0, WBout=0 next edge. Flush asserted during BUSY -> store still completes.
- TIMEOUT=4, never ack -> BusErr pulses 4 cycles after MemReq rises, WBout=0, Stall falls. Rst during BUSY -> MemReq=0 immediately.
- Word load at 0x102: with MISALIGN_TRAP_EN -> no MemReq, BusErr pulse. Without it -> MemAddr=0x100, MemBe=1111.
